// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared FSM state encoding, termination status codes and the
// termination priority helper for run_ctrl and its bench.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CPURST    = 3'd1,
    S_RUN       = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE    = 2'b00,
    ST_HALT    = 2'b01,
    ST_TIMEOUT = 2'b10,
    ST_MATCH   = 2'b11
  } status_t;

  // Status for a terminating cycle: halt beats match; otherwise it was the timeout.
  function automatic status_t term_status(input logic halt, input logic match);
    if (halt)       return ST_HALT;
    else if (match) return ST_MATCH;
    else            return ST_TIMEOUT;
  endfunction

endpackage

// File: rtl/run_ctrl_cnt.sv
// run_ctrl_cnt: clearable saturating up-counter.
//   clk, rst       : clock, synchronous active-low reset
//   i_clr          : clear to zero (wins over i_inc)
//   i_inc          : increment by one, holding at all-ones
//   o_cnt          : current count
//   o_cnt_nxt      : count after an increment (combinational)
module run_ctrl_cnt #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt,
  output logic [W-1:0] o_cnt_nxt
);

  logic [W-1:0] r_cnt;

  assign o_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + W'(1);
  assign o_cnt     = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst)       r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc) r_cnt <= o_cnt_nxt;
  end

endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: sequences a CPU through reset, free-run or single-step execution
// and termination (halt, led match, cycle budget).
//   clk, rst             : clock, synchronous active-low reset
//   start, mode, step    : run start pulse, 0 free-run / 1 single-step, step pulse
//   pause_i, match_en    : external pause level, enable led match termination
//   halt_i, led_data_i   : CPU halt level, CPU output bus
//   cpu_rst_o, cpu_pause_o : CPU reset / pause (active high)
//   cycle_cnt_o, led_last_o: enabled-cycle count and last sampled led value
//   done_o, status_o     : run finished, termination cause
module run_ctrl #(
  parameter int unsigned          DATA_W     = 32,
  parameter int unsigned          CNT_W      = 32,
  parameter int unsigned          MAX_CYCLES = 1000,
  parameter int unsigned          RST_CYCLES = 4,
  parameter logic [DATA_W-1:0]    MATCH_VAL  = DATA_W'(32'h0000_0001)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              step,
  input  logic              pause_i,
  input  logic              match_en,
  input  logic              halt_i,
  input  logic [DATA_W-1:0] led_data_i,
  output logic              cpu_rst_o,
  output logic              cpu_pause_o,
  output logic [CNT_W-1:0]  cycle_cnt_o,
  output logic              done_o,
  output logic [1:0]        status_o,
  output logic [DATA_W-1:0] led_last_o
);

  import run_ctrl_pkg::*;

  localparam int unsigned RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t              r_state;
  state_t              w_state_nxt;
  status_t             r_status;
  logic [DATA_W-1:0]   r_led_last;
  logic [RC_W-1:0]     r_rc;
  logic                r_step_en;
  logic [CNT_W-1:0]    w_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic                w_cpu_en;
  logic                w_start_ok;
  logic                w_match;
  logic                w_timeout;
  logic                w_term;
  logic                w_rc_last;

  // A cycle is CPU-enabled when the CPU is out of reset and not paused.
  assign w_cpu_en   = ((r_state == S_RUN) && !pause_i) ||
                      ((r_state == S_STEP_WAIT) && r_step_en);
  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_match    = match_en && (led_data_i == MATCH_VAL);
  // Timeout fires on the cycle whose increment lands exactly on the budget.
  assign w_timeout  = (MAX_CYCLES != 0) && (w_cnt_nxt == CNT_W'(MAX_CYCLES));
  assign w_term     = w_cpu_en && (halt_i || w_match || w_timeout);
  assign w_rc_last  = (r_rc == RC_W'(RST_CYCLES - 1));

  run_ctrl_cnt #(.W(CNT_W)) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .i_clr     (w_start_ok),
    .i_inc     (w_cpu_en),
    .o_cnt     (w_cnt),
    .o_cnt_nxt (w_cnt_nxt)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:      if (start) w_state_nxt = S_CPURST;
      S_CPURST:    if (w_rc_last) w_state_nxt = mode ? S_STEP_WAIT : S_RUN;
      S_RUN:       if (w_term) w_state_nxt = S_DONE;
      S_STEP_WAIT: if (w_term) w_state_nxt = S_DONE;
      S_DONE:      if (start) w_state_nxt = S_CPURST;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // CPU control outputs.
  always_comb begin
    cpu_rst_o   = 1'b0;
    cpu_pause_o = 1'b1;
    done_o      = 1'b0;
    case (r_state)
      S_IDLE:      cpu_rst_o   = 1'b1;
      S_CPURST:    cpu_rst_o   = 1'b1;
      S_RUN:       cpu_pause_o = pause_i;
      S_STEP_WAIT: cpu_pause_o = !r_step_en;
      S_DONE:      done_o      = 1'b1;
      default:     cpu_rst_o   = 1'b1;
    endcase
  end

  // CPU reset phase length; restarts from zero on every entry to CPURST.
  always_ff @(posedge clk) begin
    if (!rst)                     r_rc <= '0;
    else if (r_state != S_CPURST) r_rc <= '0;
    else                          r_rc <= r_rc + RC_W'(1);
  end

  // Step grant, led capture and termination status.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_step_en  <= 1'b0;
      r_status   <= ST_NONE;
      r_led_last <= '0;
    end else begin
      // A step seen during the granted cycle itself is dropped.
      r_step_en <= (r_state == S_STEP_WAIT) && !r_step_en && step;
      if (w_start_ok) begin
        r_status   <= ST_NONE;
        r_led_last <= '0;
      end else if (w_cpu_en) begin
        r_led_last <= led_data_i;
        if (w_term) r_status <= term_status(halt_i, w_match);
      end
    end
  end

  assign cycle_cnt_o = w_cnt;
  assign status_o    = r_status;
  assign led_last_o  = r_led_last;

endmodule

// File: tb/tb_run_ctrl.sv
module tb_run_ctrl;

  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 32;
  localparam int unsigned MAXC = 10;
  localparam int unsigned RSTC = 4;
  localparam logic [31:0] MV   = 32'h0000_0001;

  logic          clk = 1'b0;
  logic          rst, start, mode, step, pause_i, match_en, halt_i;
  logic [DW-1:0] led_data_i;
  logic          cpu_rst_o, cpu_pause_o, done_o;
  logic [CW-1:0] cycle_cnt_o;
  logic [1:0]    status_o;
  logic [DW-1:0] led_last_o;

  always #5 clk = ~clk;

  run_ctrl #(
    .DATA_W(DW), .CNT_W(CW), .MAX_CYCLES(MAXC), .RST_CYCLES(RSTC), .MATCH_VAL(MV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .step(step),
    .pause_i(pause_i), .match_en(match_en), .halt_i(halt_i), .led_data_i(led_data_i),
    .cpu_rst_o(cpu_rst_o), .cpu_pause_o(cpu_pause_o), .cycle_cnt_o(cycle_cnt_o),
    .done_o(done_o), .status_o(status_o), .led_last_o(led_last_o)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: phase flags plus a countdown of remaining CPU reset cycles.
  bit          m_valid = 1'b0;
  bit          m_idle, m_run, m_done, m_smode, m_armed;
  int          m_rst_left;
  longint      m_cnt;
  logic [31:0] m_led;
  logic [1:0]  m_st;

  task automatic m_update();
    bit en;
    if (!rst) begin
      m_idle = 1; m_run = 0; m_done = 0; m_armed = 0; m_rst_left = 0;
      m_cnt = 0; m_led = '0; m_st = 2'b00; m_valid = 1;
    end else if ((m_idle || m_done) && start) begin
      m_idle = 0; m_done = 0; m_rst_left = RSTC; m_cnt = 0; m_led = '0; m_st = 2'b00;
    end else if (m_rst_left > 0) begin
      m_rst_left--;
      if (m_rst_left == 0) begin m_run = 1; m_smode = mode; m_armed = 0; end
    end else if (m_run) begin
      en = m_smode ? m_armed : !pause_i;
      m_armed = m_smode && !m_armed && step;
      if (en) begin
        if (m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
        m_led = led_data_i;
        if (halt_i)                             m_st = 2'b01;
        else if (match_en && led_data_i == MV)  m_st = 2'b11;
        else if (m_cnt == longint'(MAXC))       m_st = 2'b10;
        if (m_st != 2'b00) begin m_run = 0; m_done = 1; m_armed = 0; end
      end
    end
  endtask

  task automatic m_check();
    bit in_rst;
    if (!m_valid) return;
    in_rst = m_idle || (m_rst_left > 0);
    chk("m_cpu_rst", cpu_rst_o, in_rst);
    chk("m_cpu_pause", cpu_pause_o,
        (in_rst || m_done) ? 1'b1 : (m_smode ? !m_armed : pause_i));
    chk("m_done", done_o, m_done);
    chk("m_cnt", cycle_cnt_o, m_cnt);
    chk("m_status", status_o, m_st);
    chk("m_led_last", led_last_o, m_led);
  endtask

  // Invariant: between calls the time is just after a falling edge.
  task automatic look(); #1; m_check(); endtask
  task automatic tick(); @(posedge clk); m_update(); @(negedge clk); endtask
  task automatic cyc();  look(); tick(); endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done_o && k < budget) begin cyc(); k++; end
    chk("done_within_budget", done_o, 1'b1);
  endtask

  task automatic begin_run(input logic m);
    start = 1; mode = m; cyc();
    start = 0;
    repeat (RSTC) cyc();
  endtask

  typedef struct {
    logic rst, start, mode, step, pause, men, halt;
    logic [31:0] led;
    logic e_rst, e_pause, e_done;
    logic [31:0] e_cnt;
    logic [1:0]  e_st;
    logic [31:0] e_led;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // rst start mode step pause men halt led | cpu_rst cpu_pause done cnt status led_last
    tbl[0] = '{0,0,0,0,0,0,0,32'd0, 1,1,0,32'd0,2'b00,32'd0};
    tbl[1] = '{1,1,0,0,0,0,0,32'd0, 1,1,0,32'd0,2'b00,32'd0};
    tbl[2] = '{1,0,0,0,0,0,0,32'd0, 1,1,0,32'd0,2'b00,32'd0};
    tbl[3] = '{1,0,0,1,0,0,0,32'd0, 1,1,0,32'd0,2'b00,32'd0};
    tbl[4] = '{1,1,0,0,1,0,0,32'd0, 1,1,0,32'd0,2'b00,32'd0};
    tbl[5] = '{1,0,0,0,0,0,0,32'd0, 1,1,0,32'd0,2'b00,32'd0};
    tbl[6] = '{1,0,0,0,0,0,0,32'd5, 0,0,0,32'd0,2'b00,32'd0};
    tbl[7] = '{1,0,0,0,1,0,0,32'd7, 0,1,0,32'd1,2'b00,32'd5};
    tbl[8] = '{1,1,0,0,0,0,0,32'd9, 0,0,0,32'd1,2'b00,32'd5};
    tbl[9] = '{1,0,0,0,0,0,0,32'd3, 0,0,0,32'd2,2'b00,32'd9};

    rst = 0; start = 0; mode = 0; step = 0; pause_i = 0; match_en = 0; halt_i = 0;
    led_data_i = '0;
    @(negedge clk);
    cyc();

    // Reset, CPU reset phase and first free-run cycles.
    for (int i = 0; i < 10; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; mode = tbl[i].mode; step = tbl[i].step;
      pause_i = tbl[i].pause; match_en = tbl[i].men; halt_i = tbl[i].halt;
      led_data_i = tbl[i].led;
      look();
      chk("tbl_cpu_rst", cpu_rst_o, tbl[i].e_rst);
      chk("tbl_cpu_pause", cpu_pause_o, tbl[i].e_pause);
      chk("tbl_done", done_o, tbl[i].e_done);
      chk("tbl_cnt", cycle_cnt_o, tbl[i].e_cnt);
      chk("tbl_status", status_o, tbl[i].e_st);
      chk("tbl_led_last", led_last_o, tbl[i].e_led);
      tick();
    end

    // Timeout after 10 enabled cycles; DONE then ignores everything but start.
    start = 0;
    wait_done(20);
    look();
    chk("timeout_cnt", cycle_cnt_o, 32'd10);
    chk("timeout_status", status_o, 2'b10);
    chk("timeout_led_last", led_last_o, 32'd3);
    chk("done_cpu_pause", cpu_pause_o, 1'b1);
    chk("done_cpu_rst", cpu_rst_o, 1'b0);
    tick();
    halt_i = 1; step = 1; match_en = 1; led_data_i = MV;
    repeat (3) cyc();
    halt_i = 0; step = 0; match_en = 0; led_data_i = 32'h55;
    look();
    chk("done_hold_cnt", cycle_cnt_o, 32'd10);
    chk("done_hold_status", status_o, 2'b10);
    tick();

    // Restart from DONE, then a 5-cycle pause in the middle of the run.
    start = 1; mode = 0; cyc();
    start = 0;
    look();
    chk("restart_status", status_o, 2'b00);
    chk("restart_cnt", cycle_cnt_o, 32'd0);
    chk("restart_cpu_rst", cpu_rst_o, 1'b1);
    chk("restart_done", done_o, 1'b0);
    tick();
    repeat (RSTC - 1) cyc();
    repeat (3) cyc();
    pause_i = 1;
    for (int i = 0; i < 5; i++) begin
      look();
      chk("pause_cnt_hold", cycle_cnt_o, 32'd3);
      chk("pause_cpu_pause", cpu_pause_o, 1'b1);
      tick();
    end
    pause_i = 0;
    wait_done(20);
    chk("pause_final_cnt", cycle_cnt_o, 32'd10);
    chk("pause_final_status", status_o, 2'b10);

    // Single-step: three pulses, the second lands on the granted cycle.
    begin_run(1'b1);
    mode = 0;
    step = 1; led_data_i = 32'h10; look();
    chk("step_a_pause", cpu_pause_o, 1'b1); tick();
    step = 1; led_data_i = 32'h11; look();
    chk("step_b_pause", cpu_pause_o, 1'b0); tick();
    step = 0; led_data_i = 32'h99; look();
    chk("step_c_pause", cpu_pause_o, 1'b1);
    chk("step_c_cnt", cycle_cnt_o, 32'd1); tick();
    step = 1; look(); tick();
    step = 0; led_data_i = 32'h22; look();
    chk("step_e_pause", cpu_pause_o, 1'b0); tick();
    led_data_i = 32'h33; pause_i = 1; look();
    chk("step_f_pause", cpu_pause_o, 1'b1);
    chk("step_f_cnt", cycle_cnt_o, 32'd2);
    chk("step_f_led_last", led_last_o, 32'h22); tick();
    pause_i = 0;
    repeat (2) cyc();
    chk("step_idle_cnt", cycle_cnt_o, 32'd2);

    // Reset in the middle of a granted step cycle.
    step = 1; cyc();
    step = 0; rst = 0; look();
    chk("step_rst_pause", cpu_pause_o, 1'b0); tick();
    rst = 1; look();
    chk("step_rst_cpu_rst", cpu_rst_o, 1'b1);
    chk("step_rst_cnt", cycle_cnt_o, 32'd0);
    chk("step_rst_led", led_last_o, 32'd0);
    tick();

    // Halt and match on the same cycle as the budget: halt wins.
    begin_run(1'b0);
    led_data_i = 32'h40;
    repeat (9) cyc();
    halt_i = 1; match_en = 1; led_data_i = MV; cyc();
    halt_i = 0; match_en = 0; led_data_i = 32'h40; look();
    chk("prio_status", status_o, 2'b01);
    chk("prio_cnt", cycle_cnt_o, 32'd10);
    chk("prio_done", done_o, 1'b1);
    chk("prio_led_last", led_last_o, MV);
    tick();

    // Match termination; the match value alone does nothing without match_en.
    begin_run(1'b0);
    led_data_i = MV;
    repeat (3) cyc();
    match_en = 1; cyc();
    match_en = 0; led_data_i = 32'h7; look();
    chk("match_status", status_o, 2'b11);
    chk("match_cnt", cycle_cnt_o, 32'd4);
    tick();

    // Reset mid-run at count 5, then a clean restart from zero.
    begin_run(1'b0);
    repeat (5) cyc();
    rst = 0; look();
    chk("midrun_cnt", cycle_cnt_o, 32'd5); tick();
    rst = 1; look();
    chk("midrun_rst_cpu_rst", cpu_rst_o, 1'b1);
    chk("midrun_rst_cpu_pause", cpu_pause_o, 1'b1);
    chk("midrun_rst_cnt", cycle_cnt_o, 32'd0);
    chk("midrun_rst_status", status_o, 2'b00);
    chk("midrun_rst_done", done_o, 1'b0);
    tick();
    begin_run(1'b0);
    look();
    chk("rerun_first_cnt", cycle_cnt_o, 32'd0);
    chk("rerun_cpu_rst", cpu_rst_o, 1'b0); tick();
    look();
    chk("rerun_second_cnt", cycle_cnt_o, 32'd1); tick();

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) != 0);
      start      = ($urandom_range(0, 5) == 0);
      mode       = 1'($urandom_range(0, 1));
      step       = ($urandom_range(0, 2) == 0);
      pause_i    = ($urandom_range(0, 3) == 0);
      match_en   = 1'($urandom_range(0, 1));
      halt_i     = ($urandom_range(0, 39) == 0);
      led_data_i = ($urandom_range(0, 7) == 0) ? MV : 32'($urandom);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the observed CPU output bus.
REQ-002 SHALL have parameter CNT_W, default 32: cycle counter width.
REQ-003 SHALL have parameter MAX_CYCLES, default 1000: run budget in CPU-enabled cycles; 0 = unlimited.
REQ-004 SHALL have parameter RST_CYCLES, default 4: cycles cpu_rst_o is held asserted; minimum 1.
REQ-005 SHALL have parameter MATCH_VAL, default 32'h0000_0001: led value that ends a run when match_en=1.
REQ-006 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-007 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-008 SHALL have port start  in  1  single-cycle pulse, begins a run from IDLE or DONE.
REQ-009 SHALL have port mode  in  1  0 = free-run, 1 = single-step.
REQ-010 SHALL have port step  in  1  single-cycle pulse, advances CPU one cycle in single-step mode.
REQ-011 SHALL have port pause_i  in  1  external pause request, level.
REQ-012 SHALL have port match_en  in  1  enables MATCH_VAL termination.
REQ-013 SHALL have port halt_i  in  1  CPU halt indication (e.g. ecall retired), level.
REQ-014 SHALL have port led_data_i  in  DATA_W  CPU output bus.
REQ-015 SHALL have port cpu_rst_o  out  1  active-high reset to CPU.
REQ-016 SHALL have port cpu_pause_o  out  1  active-high pause to CPU.
REQ-017 SHALL have port cycle_cnt_o  out  CNT_W  count of CPU-enabled cycles this run.
REQ-018 SHALL have port done_o  out  1  high while in DONE.
REQ-019 SHALL have port status_o  out  2  00 none, 01 halt, 10 timeout, 11 match.
REQ-020 SHALL have port led_last_o  out  DATA_W  led_data_i sampled on the last CPU-enabled cycle.

Function
REQ-021 SHALL implement FSM states IDLE, CPURST, RUN, STEP_WAIT, DONE.
REQ-022 IDLE: cpu_rst_o=1, cpu_pause_o=1; start -> CPURST, clearing cycle_cnt_o, status_o, led_last_o.
REQ-023 CPURST: cpu_rst_o=1, cpu_pause_o=1 for exactly RST_CYCLES cycles, then -> RUN (mode=0) or STEP_WAIT (mode=1); mode sampled on this transition only.
REQ-024 RUN: cpu_rst_o=0; cpu_pause_o equals pause_i combinationally; a cycle with cpu_pause_o=0 is CPU-enabled.
REQ-025 STEP_WAIT: cpu_pause_o=1 except during the cycle following a step pulse, which is the one CPU-enabled cycle; step during that cycle is ignored; pause_i is ignored.
REQ-026 Each CPU-enabled cycle SHALL increment cycle_cnt_o by 1, saturating at all-ones, and load led_last_o from led_data_i.
REQ-027 Termination evaluated only on CPU-enabled cycles, priority halt_i > match (match_en and led_data_i==MATCH_VAL) > timeout (MAX_CYCLES!=0 and count reaching MAX_CYCLES); next cycle -> DONE with status_o set.
REQ-028 DONE: cpu_pause_o=1, cpu_rst_o=0, done_o=1; outputs hold; start -> CPURST (restart), anything else ignored.
REQ-029 start outside IDLE/DONE SHALL be ignored.
REQ-030 At most one termination status is recorded per run; status_o changes only on entry to DONE or on restart.

Reset
REQ-031 rst=0 at a clock edge SHALL force IDLE, cycle_cnt_o=0, status_o=00, led_last_o=0, done_o=0 from any state, including mid-CPURST or mid-step.
REQ-032 During and after reset until start, cpu_rst_o=1 and cpu_pause_o=1.

Structure
REQ-033 State encoding and status_o codes SHALL live in a shared package (run_ctrl_pkg) for bench reuse.
REQ-034 The RST_CYCLES/run counter pair MAY be one sub-module, run_ctrl_cnt (loadable saturating counter); no other hierarchy.

Verification
REQ-035 Free-run, MAX_CYCLES=10, halt_i=0, match_en=0 -> cpu_rst_o high 4 cycles after start, done_o after 10 enabled cycles, cycle_cnt_o=10, status_o=10.
REQ-036 Free-run, pause_i high for 5 cycles mid-run -> cycle_cnt_o does not advance during pause, final count still 10.
REQ-037 Single-step, 3 step pulses, one issued during enabled cycle -> exactly 2 enabled cycles, cycle_cnt_o=2, led_last_o = led value of 2nd.
REQ-038 halt_i and led_data_i==MATCH_VAL with match_en=1 on same cycle as 10th count -> status_o=01.
REQ-039 rst=0 asserted mid-RUN at count 5 -> next cycle IDLE, all outputs at reset values; subsequent start restarts at count 0.
REQ-040 start pulse in DONE -> new CPURST, status_o=00, cycle_cnt_o=0.
